pico_bus_master: RTL and testbench

// Synthesizable initiator for the Pico-side 8-bit parallel bus of the SIMD core (CS/WR/RD/CD/excute/direction).

---
 rtl/pico_bus_master.sv | 165 ++++++++++++++++
 tb/tb_pico_bus_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pico_bus_master.sv
// pico_bus_master: command-driven initiator for the Pico-side 8-bit parallel bus.
// Converts WRITE_REG / EXECUTE / READ_BURST / ADDR_ONLY commands into timed
// CS/WR/RD/CD/excute/direction bus cycles; read bytes come back on rsp_valid.
module pico_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 2,
    parameter int TURN_CYC   = 2,
    parameter int EXEC_CYC   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_len,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic       CD,
    output logic       excute,
    output logic       direction,
    output logic [7:0] pico_data_o,
    output logic       pico_data_oe,
    input  logic [7:0] pico_data_i
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_EXEC  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ADDR  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_D_SETUP, S_D_STROBE, S_D_HOLD,
        S_EXEC, S_TURN_IN, S_RD_HI, S_RD_LO, S_TURN_OUT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] r_beats;
    logic [1:0] r_op;
    logic [7:0] r_wdata;
    logic [7:0] r_data;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       w_cnt_done;
    logic       w_accept;
    logic       w_rd_capture;

    // Counter preload: a state with parameter N lasts N cycles, so load N-1.
    function automatic logic [7:0] f_reload(state_t s);
        case (s)
            S_A_SETUP, S_D_SETUP:   f_reload = 8'(SETUP_CYC - 1);
            S_A_STROBE, S_D_STROBE,
            S_RD_HI:                f_reload = 8'(STROBE_CYC - 1);
            S_A_HOLD, S_D_HOLD,
            S_RD_LO:                f_reload = 8'(HOLD_CYC - 1);
            S_TURN_IN, S_TURN_OUT:  f_reload = 8'(TURN_CYC - 1);
            S_EXEC:                 f_reload = 8'(EXEC_CYC - 1);
            default:                f_reload = 8'd0;
        endcase
    endfunction

    assign w_cnt_done   = (r_cnt == 8'd0);
    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_rd_capture = (r_state == S_RD_HI) && w_cnt_done;

    // Next-state: every state holds until its timing counter expires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE, OP_ADDR: w_state_nxt = S_A_SETUP;
                        OP_EXEC:           w_state_nxt = S_EXEC;
                        default:           w_state_nxt = S_TURN_IN;
                    endcase
                end
            end
            S_A_SETUP:  if (w_cnt_done) w_state_nxt = S_A_STROBE;
            S_A_STROBE: if (w_cnt_done) w_state_nxt = S_A_HOLD;
            S_A_HOLD:   if (w_cnt_done) w_state_nxt = (r_op == OP_WRITE) ? S_D_SETUP : S_IDLE;
            S_D_SETUP:  if (w_cnt_done) w_state_nxt = S_D_STROBE;
            S_D_STROBE: if (w_cnt_done) w_state_nxt = S_D_HOLD;
            S_D_HOLD:   if (w_cnt_done) w_state_nxt = S_IDLE;
            S_EXEC:     if (w_cnt_done) w_state_nxt = S_IDLE;
            S_TURN_IN:  if (w_cnt_done) w_state_nxt = (r_beats == 8'd0) ? S_TURN_OUT : S_RD_HI;
            S_RD_HI:    if (w_cnt_done) w_state_nxt = S_RD_LO;
            // r_beats was already decremented when leaving RD_HI
            S_RD_LO:    if (w_cnt_done) w_state_nxt = (r_beats == 8'd0) ? S_TURN_OUT : S_RD_HI;
            S_TURN_OUT: if (w_cnt_done) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // State register and per-state timing counter (reloaded on every state change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_cnt <= f_reload(w_state_nxt);
            else if (!w_cnt_done)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    // Command latch and bus drive value; address drives first, data swapped in at D_SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_WRITE;
            r_wdata <= 8'd0;
            r_data  <= 8'd0;
            r_beats <= 8'd0;
        end else begin
            if (w_accept) begin
                r_op    <= cmd_op;
                r_wdata <= cmd_wdata;
                r_data  <= cmd_addr;
                r_beats <= cmd_len;
            end else if (r_state == S_A_HOLD && w_state_nxt == S_D_SETUP) begin
                r_data <= r_wdata;
            end else if (w_rd_capture) begin
                r_beats <= r_beats - 8'd1;
            end
        end
    end

    // Read capture on the edge leaving RD_HI; response strobe lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
        end else begin
            r_rsp_valid <= w_rd_capture;
            if (w_rd_capture) r_rsp_data <= pico_data_i;
        end
    end

    // Bus outputs decoded straight from the state register so reset drops them at once.
    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = ~cmd_ready;
    assign CS           = (r_state != S_IDLE);
    assign WR           = (r_state == S_A_STROBE) || (r_state == S_D_STROBE);
    assign RD           = (r_state == S_RD_HI);
    assign CD           = (r_state == S_A_SETUP) || (r_state == S_A_STROBE) || (r_state == S_A_HOLD);
    assign excute       = (r_state == S_EXEC);
    assign direction    = (r_state == S_TURN_IN) || (r_state == S_RD_HI) ||
                          (r_state == S_RD_LO) || (r_state == S_TURN_OUT);
    assign pico_data_oe = CD || (r_state == S_D_SETUP) || (r_state == S_D_STROBE) ||
                          (r_state == S_D_HOLD);
    assign pico_data_o  = r_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_pico_bus_master.sv
// tb_pico_bus_master: directed + random commands checked cycle by cycle against
// an expected bus timeline built from phase durations.
module tb_pico_bus_master;

    localparam int SETUP = 2, STROBE = 3, HOLD = 2, TURN = 2, EXECW = 3;

    localparam logic [6:0] B_CS  = 7'b1000000;
    localparam logic [6:0] B_WR  = 7'b0100000;
    localparam logic [6:0] B_RD  = 7'b0010000;
    localparam logic [6:0] B_CD  = 7'b0001000;
    localparam logic [6:0] B_EX  = 7'b0000100;
    localparam logic [6:0] B_DIR = 7'b0000010;
    localparam logic [6:0] B_OE  = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_addr = 8'd0, cmd_wdata = 8'd0, cmd_len = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy, CS, WR, RD, CD, excute, direction, pico_data_oe;
    logic [7:0] pico_data_o;
    logic [7:0] pico_data_i = 8'd0;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  din_q[$];
    logic [7:0]  rd_vals[256];

    pico_bus_master #(
        .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD),
        .TURN_CYC(TURN), .EXEC_CYC(EXECW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .CS(CS), .WR(WR), .RD(RD), .CD(CD), .excute(excute), .direction(direction),
        .pico_data_o(pico_data_o), .pico_data_oe(pico_data_oe), .pico_data_i(pico_data_i)
    );

    always #5 clk = ~clk;

    // Observed bus; data only meaningful when its enable/strobe is high.
    function automatic logic [23:0] obs_vec();
        return {CS, WR, RD, CD, excute, direction, pico_data_oe,
                pico_data_oe ? pico_data_o : 8'h00, rsp_valid, rsp_valid ? rsp_data : 8'h00};
    endfunction

    function automatic logic [24:0] raw_vec();
        return {CS, WR, RD, CD, excute, direction, pico_data_oe, pico_data_o, rsp_valid, rsp_data, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [6:0] ctl, input logic [7:0] d, input bit rd_beat,
                        input logic [7:0] di);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ctl, d, 1'b0, 8'h00});
            din_q.push_back(rd_beat ? di : 8'($urandom));
        end
    endtask

    // Expected per-cycle bus picture of one command, starting the cycle after accept.
    task automatic build(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] len);
        int first;
        exp_q.delete();
        din_q.delete();
        case (op)
            2'b00, 2'b11: begin
                push(SETUP,  B_CS | B_CD | B_OE,        addr, 1'b0, 8'd0);
                push(STROBE, B_CS | B_WR | B_CD | B_OE, addr, 1'b0, 8'd0);
                push(HOLD,   B_CS | B_CD | B_OE,        addr, 1'b0, 8'd0);
                if (op == 2'b00) begin
                    push(SETUP,  B_CS | B_OE,        wdata, 1'b0, 8'd0);
                    push(STROBE, B_CS | B_WR | B_OE, wdata, 1'b0, 8'd0);
                    push(HOLD,   B_CS | B_OE,        wdata, 1'b0, 8'd0);
                end
            end
            2'b01: push(EXECW, B_CS | B_EX, 8'd0, 1'b0, 8'd0);
            default: begin
                push(TURN, B_CS | B_DIR, 8'd0, 1'b0, 8'd0);
                for (int k = 0; k < int'(len); k++) begin
                    push(STROBE, B_CS | B_RD | B_DIR, 8'd0, 1'b1, rd_vals[k]);
                    first = exp_q.size();
                    push(HOLD, B_CS | B_DIR, 8'd0, 1'b0, 8'd0);
                    exp_q[first][8:0] = {1'b1, rd_vals[k]};
                end
                push(TURN, B_CS | B_DIR, 8'd0, 1'b0, 8'd0);
            end
        endcase
    endtask

    // Issue one command at a negedge in IDLE; check each busy cycle; end at the next IDLE negedge.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] len, input bit junk, input int abort_at);
        build(op, addr, wdata, len);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_len = len;
        chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        chk("idle_bus", {8'd0, obs_vec()}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                cmd_valid = 1'b0;
                #1;
                chk("reset_async_outputs", {7'd0, raw_vec()}, 32'd0);
                chk("reset_async_ready", {31'd0, cmd_ready}, 32'd1);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("post_reset_rsp", {31'd0, rsp_valid}, 32'd0);
                    chk("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
                end
                return;
            end
            chk($sformatf("op%0d_cyc%0d_bus", op, c), {8'd0, obs_vec()}, {8'd0, exp_q[c]});
            chk($sformatf("op%0d_cyc%0d_busy", op, c), {30'd0, cmd_ready, busy}, 32'd1);
            pico_data_i = din_q[c];
            if (junk) begin
                cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_addr = 8'($urandom);
                cmd_wdata = 8'($urandom); cmd_len = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("ready_after_cmd", {30'd0, cmd_ready, busy}, 32'd2);
        chk("idle_after_cmd", {8'd0, obs_vec()}, 32'd0);
    endtask

    initial begin
        logic [7:0] six_addr [6];
        six_addr = '{8'd0, 8'd1, 8'd2, 8'd32, 8'd33, 8'd34};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {7'd0, raw_vec()}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // single register write: addr 64, data 0
        run_cmd(2'b00, 8'd64, 8'h00, 8'd0, 1'b0, -1);

        // six back-to-back writes with cmd_valid held (junk fields while busy)
        for (int i = 0; i < 6; i++) run_cmd(2'b00, six_addr[i], 8'h0F, 8'd0, 1'b1, -1);

        // execute pulse
        run_cmd(2'b01, 8'd0, 8'd0, 8'd0, 1'b0, -1);

        // read burst of 8, bus value = beat index
        for (int k = 0; k < 8; k++) rd_vals[k] = 8'(k);
        run_cmd(2'b10, 8'd0, 8'd0, 8'd8, 1'b0, -1);

        // zero-length read with cmd_valid hammered while busy
        run_cmd(2'b10, 8'd0, 8'd0, 8'd0, 1'b1, -1);

        // address-only phase
        run_cmd(2'b11, 8'hA5, 8'h5A, 8'd0, 1'b0, -1);

        // maximum burst length
        for (int k = 0; k < 256; k++) rd_vals[k] = 8'($urandom);
        run_cmd(2'b10, 8'd0, 8'd0, 8'd255, 1'b0, -1);

        // random command mix
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 8; k++) rd_vals[k] = 8'($urandom);
            run_cmd(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)),
                    1'($urandom), -1);
        end

        // reset during RD_HI of beat 3 (second strobe cycle)
        for (int k = 0; k < 8; k++) rd_vals[k] = 8'($urandom);
        run_cmd(2'b10, 8'd0, 8'd0, 8'd6, 1'b0, TURN + 3 * (STROBE + HOLD) + 1);

        // bus still usable after the abort
        run_cmd(2'b00, 8'h12, 8'h34, 8'd0, 1'b0, -1);
        rd_vals[0] = 8'hC3;
        rd_vals[1] = 8'h3C;
        run_cmd(2'b10, 8'd0, 8'd0, 8'd2, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
